audio_sample_capture_ctrl: RTL and testbench
============================================

AUDIO_SAMPLE_CAPTURE_CTRL -- requirements
Module: audio_sample_capture_ctrl

Interface
REQ-001 Parameter DW, default 16, sample width in bits (1..32).
REQ-002 Parameter DEPTH, default 8, FIFO depth in samples; power of two, 2..64; AW = log2(DEPTH).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 sample_in  input  DW  audio sample from the codec datapath.
REQ-006 sample_valid  input  1  one-cycle strobe, synchronous to clk; sample_in is valid in that cycle.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 read  input  1  Avalon-MM read strobe.
REQ-009 write  input  1  Avalon-MM write strobe.
REQ-010 writedata  input  32  Avalon-MM write data.
REQ-011 readdata  output  32  Avalon-MM read data, registered.
REQ-012 irq  output  1  level interrupt to the CPU.

Function
REQ-013 Register map: 0 DATA (RO), 1 STATUS (RO, W1C bit 10), 2 CONTROL (RW), 3 THRESH (RW); unused bits read 0.
REQ-014 readdata updates on the clock edge after read is sampled high (fixed 1-cycle read latency, no waitrequest); readdata holds its value while read is low.
REQ-015 DATA read: readdata = zero-extended FIFO head; the FIFO pops in the same edge; reading DATA when empty returns 0 and does not pop.
REQ-016 STATUS: [AW:0] fill level (0..DEPTH), [8] empty, [9] full, [10] overflow sticky, [11] irq_pending (level >= THRESH and THRESH != 0).
REQ-017 CONTROL: [0] enable (reset 0), [1] irq_en (reset 0), [8] flush, write-1 pulse, reads 0.
REQ-018 THRESH: [AW:0] watermark (reset 0); values > DEPTH saturate to DEPTH on write.
REQ-019 Push: sample_valid high and enable = 1 and (not full, or DATA pop in same cycle) writes sample_in at the tail; level +1.
REQ-020 Simultaneous push and pop: both occur, level unchanged, no overflow, including when full.
REQ-021 Push while full without pop: sample dropped, FIFO contents unchanged, overflow set to 1.
REQ-022 sample_valid with enable = 0: ignored, no overflow.
REQ-023 Write/read pointers are AW bits and wrap modulo DEPTH; full when level = DEPTH, empty when level = 0.
REQ-024 Flush: pointers and level cleared in the edge the write is sampled; a coincident push is discarded; overflow unaffected.
REQ-025 Writing 1 to STATUS[10] clears overflow; an overflow event in the same cycle wins (flag stays 1).
REQ-026 Simultaneous read and write in one cycle: write applies; read returns pre-write register contents.

Reset
REQ-027 On reset_n low, asynchronously: readdata = 0, irq = 0, level = 0, pointers = 0, overflow = 0, CONTROL = 0, THRESH = 0; FIFO storage not reset.
REQ-028 Reset assertion mid-operation discards all buffered samples; first push after release lands at pointer 0.

Configuration
REQ-029 Macro AUDIO_CAPTURE_IRQ_EN defined: irq = irq_en & ((level >= THRESH & THRESH != 0) | overflow), registered, asserted one cycle after the condition becomes true.
REQ-030 Macro AUDIO_CAPTURE_IRQ_EN undefined: irq tied 0, CONTROL[1] reads 0 and ignores writes, STATUS[11] still reports the watermark condition.

Verification
REQ-031 Reset, enable = 1, push 0x1234, 0xABCD; read DATA twice -> readdata 0x00001234 then 0x0000ABCD, STATUS level 0, empty = 1.
REQ-032 DEPTH = 8, push 9 samples 0x0001..0x0009 without reads -> STATUS full = 1, overflow = 1, DATA reads return 0x0001..0x0008; write STATUS 0x400 -> overflow 0.
REQ-033 FIFO full, sample_valid coincident with DATA read -> read returns oldest, new sample stored, level stays 8, overflow stays 0.
REQ-034 With AUDIO_CAPTURE_IRQ_EN: THRESH = 4, irq_en = 1, push 4 samples -> irq high one cycle after 4th push; one DATA read -> irq low next cycle.
REQ-035 Push 5 samples, write CONTROL 0x101 with coincident sample_valid -> level 0, empty = 1, DATA read returns 0; next push read back correctly.
REQ-036 Push 3 samples, assert reset_n low mid-stream for 2 cycles -> readdata 0, irq 0, level 0, CONTROL 0; pushes ignored until enable rewritten.

Source files
------------

// File: rtl/audio_sample_capture_ctrl.sv
//------------------------------------------------------------------------------
// AudioSampleCaptureCtrl
//
// Captures audio samples from the codec datapath into a small FIFO.
// The CPU drains the FIFO through an Avalon-MM slave with a fixed
// 1-cycle read latency.
//
// Register map (word address):
//   0 DATA    RO  FIFO head, zero-extended; a read pops the FIFO when it is non-empty
//   1 STATUS  RO  [AW:0] level, [8] empty, [9] full, [10] overflow (W1C),
//                 [11] watermark pending
//   2 CONTROL RW  [0] enable, [1] irq_en, [8] flush (write-1 pulse, reads 0)
//   3 THRESH  RW  [AW:0] watermark; written values above DEPTH saturate
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   sample_in     audio sample (DW bits)
//   sample_valid  one-cycle strobe qualifying sample_in
//   address       Avalon-MM word address
//   read / write  Avalon-MM strobes
//   writedata     Avalon-MM write data
//   readdata      registered Avalon-MM read data
//   irq           level interrupt
//
// Configuration macro:
//   AUDIO_CAPTURE_IRQ_EN  When defined, irq is a registered
//                         irq_en & (watermark | overflow).
//                         When undefined, irq is tied 0 and CONTROL[1]
//                         reads 0 and ignores writes.
//------------------------------------------------------------------------------
module audio_sample_capture_ctrl #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    input  logic [1:0]    address,
    input  logic          read,
    input  logic          write,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          irq
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   thresh;
    logic [AW:0]   thresh_wr;
    logic          enable;
    logic          irq_en;
    logic          overflow;

    logic          empty;
    logic          full;
    logic          watermark;
    logic          ctrl_wr;
    logic          status_wr;
    logic          thresh_wr_en;
    logic          pop;
    logic          flush;
    logic          push_req;
    logic          push;
    logic          ovf_event;
    logic [31:0]   status;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    assign empty        = (level == '0);
    assign full         = (level == LEVEL_MAX);
    assign watermark    = (thresh != '0) && (level >= thresh);

    assign ctrl_wr      = write && (address == 2'd2);
    assign status_wr    = write && (address == 2'd1);
    assign thresh_wr_en = write && (address == 2'd3);

    // A DATA read frees a slot in the same edge, so a push into a full
    // FIFO is still accepted when it coincides with a pop.
    assign pop          = read && (address == 2'd0) && !empty;
    assign flush        = ctrl_wr && writedata[8];
    assign push_req     = sample_valid && enable;
    assign push         = push_req && (!full || pop) && !flush;
    assign ovf_event    = push_req && full && !pop && !flush;

    assign thresh_wr    = (writedata > 32'(DEPTH)) ? LEVEL_MAX : writedata[AW:0];

    // Only a handful of writedata bits are decoded.
    assign unused_wdata = ^writedata;

    always_comb begin
        status         = '0;
        status[AW:0]   = level;
        status[8]      = empty;
        status[9]      = full;
        status[10]     = overflow;
        status[11]     = watermark;
    end

    // Read data is taken from the current (pre-write) register contents.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = empty ? 32'd0 : 32'(mem[rd_ptr]);
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {30'd0, irq_en, enable};
            default: rd_mux = 32'(thresh);
        endcase
    end

    // Sample storage is deliberately left unreset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b0;
            thresh   <= '0;
            readdata <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    level <= level + (AW+1)'(1);
                end else if (pop && !push) begin
                    level <= level - (AW+1)'(1);
                end
            end

            // A new overflow in the same cycle beats the W1C clear.
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (status_wr && writedata[10]) begin
                overflow <= 1'b0;
            end

            if (ctrl_wr) begin
                enable <= writedata[0];
            end
            if (thresh_wr_en) begin
                thresh <= thresh_wr;
            end

            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

`ifdef AUDIO_CAPTURE_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= writedata[1];
            end
            irq <= irq_en && (watermark || overflow);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_capture_ctrl.sv
//------------------------------------------------------------------------------
// Testbench for audio_sample_capture_ctrl (DW=16, DEPTH=8).
// Directed scenarios followed by randomized traffic, compared cycle by cycle
// against a queue-based reference model. Honours AUDIO_CAPTURE_IRQ_EN.
//------------------------------------------------------------------------------
module tb_audio_sample_capture_ctrl;

    logic        clk;
    logic        reset_n;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state
    logic [15:0] q[$];
    logic        m_enable;
    logic        m_irq_en;
    logic        m_ovf;
    int          m_thresh;
    logic [31:0] exp_rd;
    logic        exp_irq;

    audio_sample_capture_ctrl #(.DW(16), .DEPTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelStatus();
        logic [31:0] s;
        s     = '0;
        s[3:0] = 4'(q.size());
        s[8]  = (q.size() == 0);
        s[9]  = (q.size() == 8);
        s[10] = m_ovf;
        s[11] = (m_thresh != 0) && (q.size() >= m_thresh);
        return s;
    endfunction

    function automatic void modelReset();
        q.delete();
        m_enable = 1'b0;
        m_irq_en = 1'b0;
        m_ovf    = 1'b0;
        m_thresh = 0;
        exp_rd   = '0;
        exp_irq  = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, evaluated on pre-edge state.
    function automatic void modelStep(input logic sv, input logic [15:0] smp, input logic rd,
                                      input logic wr, input logic [1:0] addr,
                                      input logic [31:0] wd);
        bit full_pre, pop, flush, push_req, ovf_evt;
        full_pre = (q.size() == 8);
        if (rd) begin
            case (addr)
                2'd0:    exp_rd = (q.size() > 0) ? {16'h0, q[0]} : 32'd0;
                2'd1:    exp_rd = modelStatus();
                2'd2:    exp_rd = {30'd0, m_irq_en, m_enable};
                default: exp_rd = 32'(m_thresh);
            endcase
        end
`ifdef AUDIO_CAPTURE_IRQ_EN
        exp_irq = m_irq_en && (((m_thresh != 0) && (q.size() >= m_thresh)) || m_ovf);
`else
        exp_irq = 1'b0;
`endif
        pop      = rd && (addr == 2'd0) && (q.size() > 0);
        flush    = wr && (addr == 2'd2) && wd[8];
        push_req = sv && m_enable;
        ovf_evt  = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push_req) begin
                if (!full_pre || pop) q.push_back(smp);
                else ovf_evt = 1'b1;
            end
        end
        if (ovf_evt) m_ovf = 1'b1;
        else if (wr && (addr == 2'd1) && wd[10]) m_ovf = 1'b0;
        if (wr && (addr == 2'd2)) begin
            m_enable = wd[0];
`ifdef AUDIO_CAPTURE_IRQ_EN
            m_irq_en = wd[1];
`endif
        end
        if (wr && (addr == 2'd3)) m_thresh = (wd > 32'd8) ? 8 : int'(wd);
    endfunction

    // Drives one cycle of inputs, advances the model and checks outputs
    // 1 time unit after the edge.
    task automatic applyStimulus(input logic sv, input logic [15:0] smp, input logic rd,
                                 input logic wr, input logic [1:0] addr,
                                 input logic [31:0] wd);
        sample_valid = sv;
        sample_in    = smp;
        read         = rd;
        write        = wr;
        address      = addr;
        writedata    = wd;
        @(posedge clk);
        modelStep(sv, smp, rd, wr, addr, wd);
        #1;
        checkOutput("readdata", readdata, exp_rd);
        checkOutput("irq", {31'd0, irq}, {31'd0, exp_irq});
        sample_valid = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        address      = 2'd0;
        writedata    = '0;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, a, d);
    endtask

    task automatic readReg(input logic [1:0] a);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic pushSample(input logic [15:0] s);
        applyStimulus(1'b1, s, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    initial begin
        reset_n      = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        address      = '0;
        read         = 1'b0;
        write        = 1'b0;
        writedata    = '0;
        modelReset();
        #2;
        checkOutput("reset_readdata", readdata, 32'h0);
        checkOutput("reset_irq", {31'd0, irq}, 32'h0);
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-sample round trip
        writeReg(2'd2, 32'h1);
        pushSample(16'h1234);
        pushSample(16'hABCD);
        readReg(2'd0);
        checkOutput("data_first", readdata, 32'h0000_1234);
        readReg(2'd0);
        checkOutput("data_second", readdata, 32'h0000_ABCD);
        readReg(2'd1);
        checkOutput("status_drained", readdata, 32'h100);

        // Overflow on the ninth sample, ordered drain, W1C clear
        for (int i = 1; i <= 9; i++) pushSample(16'(i));
        readReg(2'd1);
        checkOutput("status_full_ovf", readdata, 32'h608);
        for (int i = 1; i <= 8; i++) begin
            readReg(2'd0);
            checkOutput("data_ovf_order", readdata, 32'(i));
        end
        writeReg(2'd1, 32'h400);
        readReg(2'd1);
        checkOutput("status_ovf_cleared", readdata, 32'h100);

        // Push coincident with pop while full
        for (int i = 0; i < 8; i++) pushSample(16'h0011 + 16'(i));
        applyStimulus(1'b1, 16'h0099, 1'b1, 1'b0, 2'd0, 32'h0);
        checkOutput("full_pushpop_data", readdata, 32'h0011);
        readReg(2'd1);
        checkOutput("full_pushpop_status", readdata, 32'h208);
        writeReg(2'd2, 32'h101);

        // Watermark
        writeReg(2'd3, 32'h4);
        writeReg(2'd2, 32'h3);
        for (int i = 0; i < 4; i++) pushSample(16'h0200 + 16'(i));
`ifdef AUDIO_CAPTURE_IRQ_EN
        checkOutput("irq_wm_lag", {31'd0, irq}, 32'h0);
`endif
        idleCycle();
`ifdef AUDIO_CAPTURE_IRQ_EN
        checkOutput("irq_wm_rise", {31'd0, irq}, 32'h1);
`endif
        readReg(2'd1);
        checkOutput("status_wm", readdata, 32'h804);
        readReg(2'd0);
        checkOutput("wm_data", readdata, 32'h0200);
        idleCycle();
`ifdef AUDIO_CAPTURE_IRQ_EN
        checkOutput("irq_wm_fall", {31'd0, irq}, 32'h0);
`endif
        writeReg(2'd2, 32'h101);
        writeReg(2'd3, 32'h0);

        // Flush with coincident sample
        for (int i = 0; i < 5; i++) pushSample(16'h0300 + 16'(i));
        applyStimulus(1'b1, 16'h0055, 1'b0, 1'b1, 2'd2, 32'h101);
        readReg(2'd1);
        checkOutput("flush_status", readdata, 32'h100);
        readReg(2'd0);
        checkOutput("flush_data_empty", readdata, 32'h0);
        pushSample(16'h0077);
        readReg(2'd0);
        checkOutput("flush_next_push", readdata, 32'h0077);

        // Mid-stream reset
        writeReg(2'd3, 32'h1);
        writeReg(2'd2, 32'h3);
        for (int i = 0; i < 3; i++) pushSample(16'h0400 + 16'(i));
        readReg(2'd0);
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset_readdata", readdata, 32'h0);
        checkOutput("midreset_irq", {31'd0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        readReg(2'd1);
        checkOutput("postreset_status", readdata, 32'h100);
        readReg(2'd2);
        checkOutput("postreset_control", readdata, 32'h0);
        pushSample(16'h0501);
        readReg(2'd1);
        checkOutput("postreset_push_ignored", readdata, 32'h100);
        writeReg(2'd2, 32'h1);
        pushSample(16'hBEEF);
        readReg(2'd0);
        checkOutput("postreset_first_push", readdata, 32'h0000_BEEF);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic        sv, rd, wr;
            logic [1:0]  a;
            logic [31:0] wd;
            sv = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 40);
            wr = ($urandom_range(0, 99) < 10);
            a  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            wd = $urandom;
            if (wr && (a == 2'd2)) begin
                wd[0] = ($urandom_range(0, 3) != 0);
                wd[8] = ($urandom_range(0, 5) == 0);
            end
            if (wr && (a == 2'd3) && ($urandom_range(0, 3) != 0)) begin
                wd = $urandom_range(0, 9);
            end
            applyStimulus(sv, 16'($urandom), rd, wr, a, wd);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
